// File: rtl/apb_slave_regs.sv
// apb_slave_regs: zero-wait-state APB3 slave with control, compare-match counter,
// W1C status, scratch and ID registers. Every transfer is one SETUP plus one ACCESS cycle.
module apb_slave_regs #(
    parameter int ADDRWIDTH = 8,
    parameter int DATAWIDTH = 32
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [ADDRWIDTH-1:0] paddr,
    input  logic [DATAWIDTH-1:0] pwdata,
    output logic [DATAWIDTH-1:0] prdata,
    output logic                 irq
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    localparam logic [ADDRWIDTH-3:0] W_CTRL     = (ADDRWIDTH-2)'(0);
    localparam logic [ADDRWIDTH-3:0] W_CNT_LOAD = (ADDRWIDTH-2)'(1);
    localparam logic [ADDRWIDTH-3:0] W_CNT      = (ADDRWIDTH-2)'(2);
    localparam logic [ADDRWIDTH-3:0] W_STATUS   = (ADDRWIDTH-2)'(3);
    localparam logic [ADDRWIDTH-3:0] W_SCRATCH  = (ADDRWIDTH-2)'(4);
    localparam logic [ADDRWIDTH-3:0] W_ID       = (ADDRWIDTH-2)'(5);

    localparam logic [DATAWIDTH-1:0] SCRATCH_RST = DATAWIDTH'(32'hA5A5_A5A5);
    localparam logic [DATAWIDTH-1:0] ID_VALUE    = DATAWIDTH'(32'h4150_4231);

    state_t state, state_next;

    // Decoded bus strobes for the current cycle.
    logic wr_commit;    // edge that ends a write ACCESS
    logic access_done;  // edge that ends any ACCESS (read or write)
    logic rd_capture;   // edge that ends a read SETUP
    logic proto_err;    // psel & penable seen outside a valid SETUP

    logic [ADDRWIDTH-3:0] word;
    logic                 mapped;
    logic                 wr_ctrl, wr_load, wr_status, wr_scratch;
    logic                 cnt_clr, cnt_hit;

    logic                 ctrl_en, ctrl_irq_en;
    logic [DATAWIDTH-1:0] cnt_load, cnt, scratch, rdata;
    logic [2:0]           status;       // {proto_err, addr_err, match}
    logic [2:0]           status_set, status_clr;

    // The byte offset within a word carries no meaning for this block.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^paddr[1:0];

    // Bus FSM state register.
    always_ff @(posedge pclk or negedge presetn) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (!presetn) state <= IDLE;
        else          state <= state_next;
    end

    // Bus FSM next-state logic; a protocol error always falls back to IDLE.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            IDLE:    state_next = (psel && !penable) ? SETUP : IDLE;
            SETUP:   if (!psel)        state_next = IDLE;
                     else if (penable) state_next = ACCESS;
                     else              state_next = SETUP;
            ACCESS:  if (!psel)         state_next = IDLE;
                     else if (!penable) state_next = SETUP;
                     else               state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus FSM outputs: transfer strobes derived from state and bus inputs.
    always_comb begin
        wr_commit   = 1'b0;
        access_done = 1'b0;
        proto_err   = 1'b0;
        case (state)
            SETUP: if (psel && penable) begin
                access_done = 1'b1;
                wr_commit   = pwrite;
            end
            default: proto_err = psel && penable;
        endcase
        rd_capture = psel && !penable && !pwrite;
    end

    assign word       = paddr[ADDRWIDTH-1:2];
    assign mapped     = (word <= W_ID);
    assign wr_ctrl    = wr_commit && (word == W_CTRL);
    assign wr_load    = wr_commit && (word == W_CNT_LOAD);
    assign wr_status  = wr_commit && (word == W_STATUS);
    assign wr_scratch = wr_commit && (word == W_SCRATCH);

    // A clr write beats a same-edge match so the zeroed counter never reports a stale hit.
    assign cnt_clr = wr_ctrl && pwdata[2];
    assign cnt_hit = ctrl_en && (cnt == cnt_load) && !cnt_clr;

    assign status_set = {proto_err, access_done && !mapped, cnt_hit};
    assign status_clr = wr_status ? pwdata[2:0] : 3'b000;

    // Software-writable registers: CTRL enables, compare value and scratch.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            cnt_load    <= '0;
            scratch     <= SCRATCH_RST;
        end else begin
            if (wr_ctrl) begin
                ctrl_en     <= pwdata[0];
                ctrl_irq_en <= pwdata[1];
            end
            if (wr_load)    cnt_load <= pwdata;
            if (wr_scratch) scratch  <= pwdata;
        end
    end

    // Compare-match counter: wraps to zero on reaching CNT_LOAD.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)                 cnt <= '0;
        else if (cnt_clr)             cnt <= '0;
        else if (ctrl_en) begin
            if (cnt == cnt_load)      cnt <= '0;
            else                      cnt <= cnt + DATAWIDTH'(1);
        end
    end

    // W1C status: a hardware set on the same edge as a software clear wins.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) status <= 3'b000;
        else          status <= (status & ~status_clr) | status_set;
    end

    // Read mux; unmapped words return zero.
    always_comb begin
        rdata = '0;
        case (word)
            W_CTRL:     rdata = {{(DATAWIDTH-2){1'b0}}, ctrl_irq_en, ctrl_en};
            W_CNT_LOAD: rdata = cnt_load;
            W_CNT:      rdata = cnt;
            W_STATUS:   rdata = {{(DATAWIDTH-3){1'b0}}, status};
            W_SCRATCH:  rdata = scratch;
            W_ID:       rdata = ID_VALUE;
            default:    rdata = '0;
        endcase
    end

    // Read data is captured at the end of a read SETUP and held until the next capture.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)        prdata <= '0;
        else if (rd_capture) prdata <= rdata;
    end

    assign irq = ctrl_irq_en & status[0];

endmodule

// File: tb/tb_apb_slave_regs.sv
// Testbench for apb_slave_regs: directed APB transfers, a transaction-level register
// model compared against prdata/irq every cycle, and hand-computed literal checks.
module tb_apb_slave_regs;

    logic        pclk = 1'b0;
    logic        presetn = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        irq;

    apb_slave_regs #(.ADDRWIDTH(8), .DATAWIDTH(32)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .irq     (irq)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction events announced by the driver for the upcoming clock edge.
    logic        ev_setup_rd = 1'b0;
    logic        ev_access   = 1'b0;
    logic        ev_wr       = 1'b0;
    logic        ev_proto    = 1'b0;
    logic [7:0]  ev_addr     = '0;
    logic [31:0] ev_data     = '0;

    // Register model state.
    logic        m_en, m_irq_en;
    logic [31:0] m_load, m_cnt, m_scratch, m_prdata;
    logic [2:0]  m_status;
    logic        m_irq;
    assign m_irq = m_irq_en & m_status[0];

    function automatic logic [31:0] model_read(input logic [7:0] a);
        case (a >> 2)
            8'd0:    return {30'd0, m_irq_en, m_en};
            8'd1:    return m_load;
            8'd2:    return m_cnt;
            8'd3:    return {29'd0, m_status};
            8'd4:    return m_scratch;
            8'd5:    return 32'h4150_4231;
            default: return 32'd0;
        endcase
    endfunction

    // Model: advance one edge from the transaction the driver announced.
    always @(posedge pclk or negedge presetn) begin : model
        logic        n_en, n_irq_en, clr_now;
        logic [31:0] n_load, n_cnt, n_scratch;
        logic [2:0]  n_set, n_w1c;
        if (!presetn) begin
            m_en <= 1'b0; m_irq_en <= 1'b0; m_load <= '0; m_cnt <= '0;
            m_scratch <= 32'hA5A5_A5A5; m_status <= '0; m_prdata <= '0;
        end else begin
            n_en = m_en; n_irq_en = m_irq_en; n_load = m_load; n_scratch = m_scratch;
            n_cnt = m_cnt; n_set = '0; n_w1c = '0; clr_now = 1'b0;
            if (ev_proto) n_set[2] = 1'b1;
            if (ev_access) begin
                if ((ev_addr >> 2) > 8'd5) n_set[1] = 1'b1;
                else if (ev_wr) begin
                    case (ev_addr >> 2)
                        8'd0: begin n_en = ev_data[0]; n_irq_en = ev_data[1]; clr_now = ev_data[2]; end
                        8'd1: n_load = ev_data;
                        8'd3: n_w1c = ev_data[2:0];
                        8'd4: n_scratch = ev_data;
                        default: ;
                    endcase
                end
            end
            if (clr_now) n_cnt = 0;
            else if (m_en) begin
                if (m_cnt == m_load) begin n_cnt = 0; n_set[0] = 1'b1; end
                else n_cnt = m_cnt + 1;
            end
            if (ev_setup_rd) m_prdata <= model_read(ev_addr);
            m_en <= n_en; m_irq_en <= n_irq_en; m_load <= n_load;
            m_scratch <= n_scratch; m_cnt <= n_cnt;
            m_status <= (m_status & ~n_w1c) | n_set;
        end
    end

    // Compare process: outputs against the model every cycle, away from the active edge.
    always @(negedge pclk) begin
        if (chk_on) begin
            check("prdata_vs_model", prdata, m_prdata);
            check("irq_vs_model", {31'd0, irq}, {31'd0, m_irq});
        end
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        tick();
        penable = 1'b1; ev_access = 1'b1; ev_wr = 1'b1; ev_addr = a; ev_data = d;
        tick();
        ev_access = 1'b0; ev_wr = 1'b0; psel = 1'b0; penable = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        ev_setup_rd = 1'b1; ev_addr = a;
        tick();
        ev_setup_rd = 1'b0; penable = 1'b1; ev_access = 1'b1; ev_wr = 1'b0;
        @(negedge pclk);
        d = prdata;
        tick();
        ev_access = 1'b0; psel = 1'b0; penable = 1'b0;
    endtask

    logic [31:0] rd;
    logic [31:0] rst_exp [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hA5A5_A5A5, 32'h4150_4231};

    initial begin
        #1 presetn = 1'b0;
        tick();
        chk_on = 1'b1;
        tick();
        presetn = 1'b1;
        tick();

        // Reset values of the whole map.
        for (int i = 0; i < 6; i++) begin
            apb_read(8'(i * 4), rd);
            check($sformatf("reset_val_%0d", i), rd, rst_exp[i]);
        end
        check("irq_after_reset", {31'd0, irq}, 32'd0);

        // RW scratch, RO ID.
        apb_write(8'h10, 32'hDEAD_BEEF);
        apb_read(8'h10, rd);
        check("scratch_rw", rd, 32'hDEAD_BEEF);
        apb_write(8'h14, 32'h0000_1234);
        apb_read(8'h14, rd);
        check("id_ro", rd, 32'h4150_4231);

        // Counter: match four cycles after the CTRL write commits.
        apb_write(8'h04, 32'd3);
        apb_write(8'h00, 32'h3);
        repeat (3) tick();
        check("irq_before_match", {31'd0, irq}, 32'd0);
        tick();
        check("irq_at_match", {31'd0, irq}, 32'd1);
        apb_write(8'h0C, 32'h1);
        apb_read(8'h0C, rd);
        apb_write(8'h00, 32'h4);
        apb_read(8'h08, rd);
        check("cnt_after_clr", rd, 32'd0);
        apb_read(8'h00, rd);
        check("ctrl_after_clr", rd, 32'd0);
        check("irq_after_ctrl_clear", {31'd0, irq}, 32'd0);
        apb_write(8'h0C, 32'h7);
        apb_read(8'h0C, rd);
        check("status_cleared", rd, 32'd0);

        // Unmapped read and addr_err W1C.
        apb_read(8'h40, rd);
        check("unmapped_read", rd, 32'd0);
        apb_read(8'h0C, rd);
        check("addr_err_set", rd, 32'h2);
        apb_write(8'h0C, 32'h2);
        apb_read(8'h0C, rd);
        check("addr_err_w1c", rd, 32'd0);

        // Protocol error: penable with psel straight from IDLE.
        tick();
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'h0BAD_F00D;
        ev_proto = 1'b1;
        tick();
        ev_proto = 1'b0; psel = 1'b0; penable = 1'b0;
        tick();
        apb_read(8'h10, rd);
        check("scratch_after_proto", rd, 32'hDEAD_BEEF);
        apb_read(8'h0C, rd);
        check("proto_err_set", rd, 32'h4);
        apb_write(8'h0C, 32'h4);

        // Back-to-back write then read with psel held high.
        apb_write(8'h10, 32'hCAFE_F00D);
        apb_read(8'h10, rd);
        check("b2b_read", rd, 32'hCAFE_F00D);

        // CNT_LOAD=0: match every cycle; the set beats a same-edge W1C clear.
        apb_write(8'h04, 32'd0);
        apb_write(8'h00, 32'h3);
        tick();
        check("irq_load0", {31'd0, irq}, 32'd1);
        apb_write(8'h0C, 32'h1);
        apb_read(8'h0C, rd);
        check("match_set_wins", rd, 32'h1);
        apb_write(8'h00, 32'h2);

        // Reset during an ACCESS write aborts it.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'h1111_2222;
        tick();
        penable = 1'b1;
        #2 presetn = 1'b0;
        #1;
        check("prdata_in_reset", prdata, 32'd0);
        check("irq_in_reset", {31'd0, irq}, 32'd0);
        psel = 1'b0; penable = 1'b0;
        repeat (2) tick();
        presetn = 1'b1;
        tick();
        apb_read(8'h10, rd);
        check("scratch_after_reset", rd, 32'hA5A5_A5A5);
        apb_read(8'h00, rd);
        check("ctrl_after_reset", rd, 32'd0);
        apb_read(8'h0C, rd);
        check("status_after_reset", rd, 32'd0);

        tick();
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_slave_regs.md
# apb_slave_regs

APB3-style zero-wait-state slave register block. It is the downstream consumer of the APB bus driven by the verification driver and sampled by the monitor. It decodes psel/penable/pwrite/paddr/pwdata, returns prdata, and implements a small register map: control, a compare-match counter, a W1C status register, a scratch register and an ID. The bus has no pready and no pslverr, so every transfer completes in exactly one SETUP cycle plus one ACCESS cycle. This block is the DUT for the register-abstraction-layer tests.

## Interface
- ADDRWIDTH, 8, paddr width; bits [1:0] are ignored and word decode uses paddr[ADDRWIDTH-1:2]
- DATAWIDTH, 32, pwdata/prdata width; only 32 is supported
- pclk  in  1  bus clock; all state is clocked on its rising edge
- presetn  in  1  asynchronous active-low reset
- psel  in  1  slave select
- penable  in  1  access-phase strobe
- pwrite  in  1  1 = write, 0 = read
- paddr  in  ADDRWIDTH  byte address
- pwdata  in  DATAWIDTH  write data
- prdata  out  DATAWIDTH  read data, registered
- irq  out  1  interrupt, equal to CTRL.irq_en & STATUS.match

## Operation
- Bus FSM states: IDLE, SETUP, ACCESS.
  - IDLE→SETUP when psel=1 and penable=0.
  - SETUP→ACCESS when psel=1 and penable=1.
  - ACCESS→SETUP when psel=1 and penable=0 (back-to-back transfer).
  - ACCESS→IDLE when psel=0.
  - IDLE or ACCESS with psel=1 and penable=1 is a protocol error: set STATUS.proto_err, do not perform any transfer, go to IDLE.
  - SETUP with psel=0 is an abandoned transfer: go to IDLE, no error.
- Register map (offset, access, reset value):
  - 0x00 CTRL, RW, 0. bit0 en, bit1 irq_en, bit2 clr. clr is self-clearing: writing 1 zeroes CNT on the write edge and clr always reads back 0.
  - 0x04 CNT_LOAD, RW, 0. Compare value.
  - 0x08 CNT, RO, 0. Counter.
  - 0x0C STATUS, W1C, 0. bit0 match, bit1 addr_err, bit2 proto_err.
  - 0x10 SCRATCH, RW, 0xA5A5_A5A5.
  - 0x14 ID, RO, 0x4150_4231.
  - 0x18 and above: unmapped. Reads return 0, writes are ignored, and any access sets STATUS.addr_err.
- Writes to RO registers are ignored and do not set an error.
- Counter, per cycle:
  - en=1 and CNT==CNT_LOAD: CNT←0 and set STATUS.match.
  - en=1 otherwise: CNT←CNT+1, with modulo-2^32 wrap.
  - en=0: CNT holds.
  - CNT_LOAD=0 with en=1 sets match every cycle.
- Simultaneous events:
  - A hardware set of a STATUS bit on the same edge as a W1C clear of that bit: the set wins and the bit stays 1.
  - CTRL.clr and a counter match on the same edge: clr wins and match is not set.
  - A CNT_LOAD write: the new value is used for the compare from the next cycle.
- Unused CTRL/STATUS bits read 0 and are not writable.

## Timing
- Write commit: on the rising edge that ends ACCESS (psel=1, penable=1, pwrite=1). The new value is visible from the next cycle.
- Read capture: prdata is loaded on the rising edge that ends SETUP (psel=1, penable=0, pwrite=0) with the register value at that edge. It is stable throughout ACCESS and held until the next read capture. CNT therefore returns its value at the SETUP edge.
- Write transfers and idle cycles do not change prdata.
- Transfer length: 2 cycles, no wait states; a back-to-back stream sustains one transfer per 2 cycles.
- irq is combinational from flops with no input-to-output path, so it is glitch-free relative to pclk.
- Reset (asynchronous assert, synchronous-clean deassert by the environment):
  - FSM goes to IDLE, prdata=0, irq=0, and all registers take their reset values.
  - Reset asserted mid-transfer aborts the transfer with no partial write.

## Test plan
- Reset values: release reset, read 0x00–0x14. Expect 0, 0, 0, 0, 0xA5A5_A5A5, 0x4150_4231. irq=0 throughout.
- RW/RO: write 0xDEAD_BEEF to SCRATCH, then read → 0xDEAD_BEEF. Write 0x1234 to ID, then read → 0x4150_4231.
- Counter:
  - Write CNT_LOAD=3 and CTRL=0x3; expect STATUS.match=1 and irq=1 four cycles after the CTRL write commits.
  - Write 0x1 to STATUS; expect match=0 unless a new match occurs on the same edge.
  - Write CTRL=0x4; expect CNT reads 0 and CTRL reads 0 (en and irq_en cleared by the write).
- Unmapped and W1C: read 0x40 → 0 and STATUS.addr_err=1. Write 0x2 to STATUS → addr_err=0, other bits unchanged.
- Protocol error: drive psel=1, penable=1 directly from IDLE with a write to SCRATCH. Expect SCRATCH unchanged and STATUS.proto_err=1.
- Back-to-back and reset:
  - Write SCRATCH then read SCRATCH with psel held high; expect the new data in the read's ACCESS cycle.
  - Assert presetn during an ACCESS write; expect SCRATCH=0xA5A5_A5A5 and prdata=0 immediately.
